stim_pattern_gen: RTL and testbench
===================================

// Module: stim_pattern_gen
// PURPOSE
//   Synthesizable stimulus source that drives the DUT input of the top-level bench.
//   On a start pulse it emits a programmed number of bursts of patterned data words
//   on a valid/ready stream, with programmable idle gaps between bursts.
//   It signals completion with a one-cycle done pulse, so bench stimulus is a register write, not procedural code.
// PARAMETERS
//   DATA_W  32             stream data width; legal range 8..32
//   LEN_W   16             width of burst_len and of beats-per-burst counter
//   GAP_W   8              width of gap_cycles
//   SEED    32'hACE1_2468  LFSR seed reloaded on each start; a value of 0 is replaced by 1
// PORTS
//   clk         in   1       clock (global bench clock)
//   reset       in   1       asynchronous, active-low reset
//   start       in   1       one-cycle request to begin a run; accepted only in IDLE
//   mode        in   2       0=counter, 1=LFSR, 2=constant, 3=walking-one
//   const_val   in   DATA_W  word used in mode 2
//   burst_len   in   LEN_W   beats per burst
//   num_bursts  in   16      bursts per run
//   gap_cycles  in   GAP_W   idle cycles between bursts
//   m_valid     out  1       stream data valid
//   m_data      out  DATA_W  stream data
//   m_last      out  1       high on final beat of each burst
//   m_ready     in   1       downstream (DUT) ready
//   busy        out  1       high from the cycle after start is accepted until done
//   done        out  1       one-cycle pulse at end of run
//   beat_count  out  32      beats accepted in the current run
// BEHAVIOUR
//   - Reset (async assert, any state): all outputs 0, FSM=IDLE, LFSR=SEED, counters cleared.
//     Release is synchronous to clk.
//   - FSM states and transitions:
//       IDLE -> SEND on start.
//       SEND -> GAP, SEND or DONE after the last beat of a burst is accepted.
//       GAP  -> SEND once gap_cycles have elapsed.
//       DONE -> IDLE after exactly 1 cycle.
//   - Start in IDLE:
//       * Latch mode, const_val, burst_len, num_bursts and gap_cycles.
//       * Clear beat_count; reset pattern state (counter=0, LFSR=SEED, walking-one=1).
//       * m_valid is high in the next cycle (latency 1).
//   - start outside IDLE is ignored; it has no effect on latched config.
//   - burst_len==0 or num_bursts==0: IDLE->DONE; done in next cycle; m_valid never asserts.
//   - Handshake: a beat transfers when m_valid&&m_ready.
//     While m_valid=1 and m_ready=0, m_data and m_last hold stable.
//     m_valid never drops without a transfer, except on reset.
//   - Pattern advances only on a transfer:
//       counter: +1 mod 2^DATA_W.
//       LFSR: 32-bit Galois, s' = (s>>1) ^ (s[0] ? 32'h8020_0003 : 0), m_data = s[DATA_W-1:0].
//       constant: const_val.
//       walking-one: rotate left by 1.
//   - Pattern state continues across bursts within a run; it is not reset per burst.
//   - m_last=1 on beat burst_len of each burst.
//   - After the last beat of a burst:
//       * More bursts remain, gap_cycles>0: GAP, m_valid=0 for exactly gap_cycles cycles, then SEND.
//       * More bursts remain, gap_cycles==0: next burst begins next cycle; m_valid stays 1 (back-to-back).
//       * Final burst: DONE; done=1 and busy=0 in that cycle; then IDLE.
//   - beat_count: +1 per transfer; wraps at 2^32; holds its value after done until next start.
//   - Reset mid-run: m_valid drops immediately (async); partial beats are discarded.
//     The next start after release behaves as a fresh run.
// TESTING
//   T1 mode0, len=4, bursts=2, gap=3, ready=1:
//      m_data 0,1,2,3 (last on 3); 3 cycles valid=0; then 4,5,6,7 (last on 7);
//      done pulse; beat_count=8.
//   T2 as T1 with m_ready toggling 1,0,0,1,...:
//      data stable while stalled; sequence 0..7 with no loss or duplication;
//      done only after the 8th transfer.
//   T3 mode1, SEED=1, len=3, bursts=1, DATA_W=32:
//      m_data 32'h0000_0001, 32'h8020_0003, 32'hC030_0002; m_last on third beat.
//   T4 burst_len=0, bursts=5:
//      start -> done next cycle; m_valid stays 0; beat_count=0.
//   T5 start pulsed again mid-run: ignored, run completes unchanged.
//      Then reset asserted mid-burst: m_valid=0 the same cycle.
//      After release, new start (mode2, const_val=32'hDEAD_BEEF, len=2) -> two beats of 32'hDEAD_BEEF.
//   T6 DATA_W=8, mode0, len=260, gap=0, bursts=2:
//      data wraps 8'hFF -> 8'h00; m_last on beats 260 and 520; valid continuous; beat_count=520.

Source files
------------

// File: rtl/stim_pattern_gen.sv
// Stimulus source: on start, emits num_bursts bursts of burst_len patterned words
// on a valid/ready stream, with gap_cycles idle cycles between bursts, then pulses done.
module stim_pattern_gen #(
    parameter int          DATA_W = 32,
    parameter int          LEN_W  = 16,
    parameter int          GAP_W  = 8,
    parameter logic [31:0] SEED   = 32'hACE1_2468
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] const_val,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic [15:0]       num_bursts,
    input  logic [GAP_W-1:0]  gap_cycles,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
    output logic [31:0]       beat_count
);

    // A zero seed would lock the LFSR at zero forever.
    localparam logic [31:0] SEED_INIT = (SEED == 32'd0) ? 32'd1 : SEED;

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    state_t            state, state_next;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] const_q;
    logic [LEN_W-1:0]  len_q;
    logic [15:0]       nb_q;
    logic [GAP_W-1:0]  gap_q;
    logic [LEN_W-1:0]  beat_idx;
    logic [15:0]       burst_idx;
    logic [GAP_W-1:0]  gap_cnt;
    logic [DATA_W-1:0] cnt_q;
    logic [31:0]       lfsr_q;
    logic [DATA_W-1:0] walk_q;
    logic [31:0]       beat_cnt_q;

    logic start_ok, empty_run, xfer, last_beat, last_burst, gap_end;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0000_0000);
    endfunction

    function automatic logic [DATA_W-1:0] walk_step(input logic [DATA_W-1:0] w);
        return {w[DATA_W-2:0], w[DATA_W-1]};
    endfunction

    assign start_ok   = (state == IDLE) && start;
    assign empty_run  = (burst_len == '0) || (num_bursts == 16'd0);
    assign xfer       = (state == SEND) && m_ready;
    assign last_beat  = (beat_idx == len_q - LEN_W'(1));
    assign last_burst = (burst_idx == nb_q - 16'd1);
    assign gap_end    = (gap_cnt == gap_q - GAP_W'(1));

    // State register; reset drops m_valid immediately since it decodes from state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic: bursts end on the accepted last beat, then gap, repeat or finish.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = empty_run ? DONE : SEND;
            SEND: begin
                if (xfer && last_beat) begin
                    if (last_burst)          state_next = DONE;
                    else if (gap_q == '0)    state_next = SEND;
                    else                     state_next = GAP;
                end
            end
            GAP:  if (gap_end) state_next = SEND;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Config capture, beat/burst/gap counters and pattern state; patterns advance only on transfers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q     <= '0;
            const_q    <= '0;
            len_q      <= '0;
            nb_q       <= '0;
            gap_q      <= '0;
            beat_idx   <= '0;
            burst_idx  <= '0;
            gap_cnt    <= '0;
            cnt_q      <= '0;
            lfsr_q     <= SEED_INIT;
            walk_q     <= DATA_W'(1);
            beat_cnt_q <= '0;
        end else if (start_ok) begin
            mode_q     <= mode;
            const_q    <= const_val;
            len_q      <= burst_len;
            nb_q       <= num_bursts;
            gap_q      <= gap_cycles;
            beat_idx   <= '0;
            burst_idx  <= '0;
            gap_cnt    <= '0;
            cnt_q      <= '0;
            lfsr_q     <= SEED_INIT;
            walk_q     <= DATA_W'(1);
            beat_cnt_q <= '0;
        end else begin
            if (xfer) begin
                cnt_q      <= cnt_q + DATA_W'(1);
                lfsr_q     <= lfsr_step(lfsr_q);
                walk_q     <= walk_step(walk_q);
                beat_cnt_q <= beat_cnt_q + 32'd1;
                if (last_beat) begin
                    beat_idx  <= '0;
                    burst_idx <= burst_idx + 16'd1;
                end else begin
                    beat_idx  <= beat_idx + LEN_W'(1);
                end
            end
            if (state == GAP) gap_cnt <= gap_end ? '0 : gap_cnt + GAP_W'(1);
        end
    end

    // Output word selected by the latched mode.
    always_comb begin
        m_data = cnt_q;
        case (mode_q)
            2'd0:    m_data = cnt_q;
            2'd1:    m_data = lfsr_q[DATA_W-1:0];
            2'd2:    m_data = const_q;
            2'd3:    m_data = walk_q;
            default: m_data = cnt_q;
        endcase
    end

    assign m_valid    = (state == SEND);
    assign m_last     = (state == SEND) && last_beat;
    assign busy       = (state == SEND) || (state == GAP);
    assign done       = (state == DONE);
    assign beat_count = beat_cnt_q;

endmodule

// File: tb/tb_stim_pattern_gen.sv
// Directed bench for stim_pattern_gen: a 32-bit instance (SEED=1) and an 8-bit instance.
module tb_stim_pattern_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, start8;
    logic [1:0]  mode;
    logic [31:0] const_val;
    logic [15:0] burst_len;
    logic [15:0] num_bursts;
    logic [7:0]  gap_cycles;
    logic        m_ready;

    logic        m_valid, m_last, busy, done;
    logic [31:0] m_data, beat_count;
    logic        m_valid8, m_last8, busy8, done8;
    logic [7:0]  m_data8;
    logic [31:0] beat_count8;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] cap_data[$];
    bit          cap_last[$];
    bit          vld_log[$];
    bit          got_done, busy_at_done;
    int          done_cyc, stall_err, xfers_at_done;

    // Free-running bench clock.
    always #5 clk = ~clk;

    stim_pattern_gen #(.DATA_W(32), .LEN_W(16), .GAP_W(8), .SEED(32'h0000_0001)) u_dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .const_val(const_val),
        .burst_len(burst_len), .num_bursts(num_bursts), .gap_cycles(gap_cycles),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .busy(busy), .done(done), .beat_count(beat_count)
    );

    stim_pattern_gen #(.DATA_W(8), .LEN_W(16), .GAP_W(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .mode(mode), .const_val(const_val[7:0]),
        .burst_len(burst_len), .num_bursts(num_bursts), .gap_cycles(gap_cycles),
        .m_valid(m_valid8), .m_data(m_data8), .m_last(m_last8), .m_ready(m_ready),
        .busy(busy8), .done(done8), .beat_count(beat_count8)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input logic [1:0] m, input logic [31:0] cv, input logic [15:0] len,
                           input logic [15:0] nb, input logic [7:0] gap);
        mode = m; const_val = cv; burst_len = len; num_bursts = nb; gap_cycles = gap;
    endtask

    task automatic pulse_start(input bit eight);
        @(posedge clk); #1;
        if (eight) start8 = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start8 = 1'b0;
    endtask

    // Runs cycle by cycle until done (or budget), logging transfers and checking stall stability.
    task automatic collect(input bit eight, input int ready_pat, input int max_cyc, input int inject_at);
        int cyc;
        bit v, l, dn, b, pv, pr, pl;
        logic [31:0] d, pd;
        cap_data.delete(); cap_last.delete(); vld_log.delete();
        got_done = 0; busy_at_done = 0; done_cyc = -1; stall_err = 0; xfers_at_done = -1;
        cyc = 0; pv = 0; pr = 1; pl = 0; pd = '0;
        while (!got_done && cyc < max_cyc) begin
            m_ready = (ready_pat == 0) ? 1'b1 : (cyc % 3 == 0);
            if (inject_at >= 0 && cyc == inject_at) begin
                start = 1'b1; mode = 2'd2; burst_len = 16'd1; num_bursts = 16'd9; gap_cycles = 8'd0;
            end else if (inject_at >= 0 && cyc == inject_at + 1) begin
                start = 1'b0;
            end
            @(negedge clk);
            if (eight) begin
                v = m_valid8; d = {24'h0, m_data8}; l = m_last8; dn = done8; b = busy8;
            end else begin
                v = m_valid; d = m_data; l = m_last; dn = done; b = busy;
            end
            vld_log.push_back(v);
            if (pv && !pr && !(v && d == pd && l == pl)) stall_err++;
            if (v && m_ready) begin
                cap_data.push_back(d);
                cap_last.push_back(l);
            end
            if (dn) begin
                got_done = 1; done_cyc = cyc; busy_at_done = b; xfers_at_done = cap_data.size();
            end
            pv = v; pr = m_ready; pd = d; pl = l;
            @(posedge clk); #1;
            cyc++;
        end
        m_ready = 1'b1;
        start = 1'b0;
        check_val("done_seen", got_done, 1);
    endtask

    // Checks a counter-mode run of 8 beats in two bursts of 4.
    task automatic check_two_by_four(input string t);
        check_val({t, "_nbeats"}, cap_data.size(), 8);
        for (int i = 0; i < cap_data.size() && i < 8; i++) begin
            check_val($sformatf("%s_data%0d", t, i), cap_data[i], i);
            check_val($sformatf("%s_last%0d", t, i), cap_last[i], (i == 3 || i == 7));
        end
        check_val({t, "_xfers_at_done"}, xfers_at_done, 8);
        check_val({t, "_busy_at_done"}, busy_at_done, 0);
        check_val({t, "_beat_count"}, beat_count, 8);
    endtask

    initial begin
        logic [31:0] vbits;
        int          errs, vcnt;
        reset = 1'b0; start = 1'b0; start8 = 1'b0; m_ready = 1'b1;
        set_cfg(2'd0, 32'h0, 16'd0, 16'd0, 8'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_valid", m_valid, 0);
        check_val("rst_data", m_data, 0);
        check_val("rst_last", m_last, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_beat_count", beat_count, 0);
        @(posedge clk); #1; reset = 1'b1;

        // T1: counter, 2 bursts of 4, gap 3, ready always high
        set_cfg(2'd0, 32'h0, 16'd4, 16'd2, 8'd3);
        pulse_start(0);
        check_val("t1_busy_first", busy, 1);
        collect(0, 0, 100, -1);
        check_two_by_four("t1");
        vbits = '0;
        for (int i = 0; i < vld_log.size() && i < 32; i++) vbits[i] = vld_log[i];
        check_val("t1_ncycles", vld_log.size(), 12);
        check_val("t1_valid_trace", vbits, 32'h0000_078F);
        check_val("t1_done_cyc", done_cyc, 11);
        check_val("t1_done_pulse", done, 0);

        // T2: same run with ready toggling 1,0,0,...
        pulse_start(0);
        collect(0, 1, 200, -1);
        check_two_by_four("t2");
        check_val("t2_stall_hold", stall_err, 0);

        // T3: LFSR from seed 1
        set_cfg(2'd1, 32'h0, 16'd3, 16'd1, 8'd0);
        pulse_start(0);
        collect(0, 0, 50, -1);
        check_val("t3_nbeats", cap_data.size(), 3);
        if (cap_data.size() == 3) begin
            check_val("t3_data0", cap_data[0], 32'h0000_0001);
            check_val("t3_data1", cap_data[1], 32'h8020_0003);
            check_val("t3_data2", cap_data[2], 32'hC030_0002);
            check_val("t3_last", {cap_last[0], cap_last[1], cap_last[2]}, 3'b001);
        end

        // T4: zero-length bursts finish immediately
        set_cfg(2'd0, 32'h0, 16'd0, 16'd5, 8'd0);
        pulse_start(0);
        collect(0, 0, 10, -1);
        check_val("t4_done_cyc", done_cyc, 0);
        check_val("t4_nbeats", cap_data.size(), 0);
        check_val("t4_beat_count", beat_count, 0);

        // T5a: start pulsed mid-run with different config is ignored
        set_cfg(2'd0, 32'h0, 16'd4, 16'd2, 8'd3);
        pulse_start(0);
        collect(0, 0, 100, 2);
        check_two_by_four("t5");
        check_val("t5_done_cyc", done_cyc, 11);

        // T5b: reset mid-burst drops valid at once
        set_cfg(2'd0, 32'h0, 16'd4, 16'd1, 8'd0);
        pulse_start(0);
        @(posedge clk); #3;
        check_val("t5_valid_before_rst", m_valid, 1);
        reset = 1'b0;
        #1;
        check_val("t5_valid_in_rst", m_valid, 0);
        check_val("t5_busy_in_rst", busy, 0);
        check_val("t5_count_in_rst", beat_count, 0);
        @(posedge clk); #1; reset = 1'b1;

        // T5c: fresh constant-mode run after reset
        set_cfg(2'd2, 32'hDEAD_BEEF, 16'd2, 16'd1, 8'd0);
        pulse_start(0);
        collect(0, 0, 50, -1);
        check_val("t5c_nbeats", cap_data.size(), 2);
        if (cap_data.size() == 2) begin
            check_val("t5c_data0", cap_data[0], 32'hDEAD_BEEF);
            check_val("t5c_data1", cap_data[1], 32'hDEAD_BEEF);
            check_val("t5c_last", {cap_last[0], cap_last[1]}, 2'b01);
        end
        check_val("t5c_beat_count", beat_count, 2);

        // T6: 8-bit counter wraps, back-to-back bursts of 260
        set_cfg(2'd0, 32'h0, 16'd260, 16'd2, 8'd0);
        pulse_start(1);
        collect(1, 0, 700, -1);
        check_val("t6_nbeats", cap_data.size(), 520);
        errs = 0;
        for (int i = 0; i < cap_data.size(); i++) begin
            if (cap_data[i] != (i % 256)) errs++;
            if (cap_last[i] != (i == 259 || i == 519)) errs++;
        end
        check_val("t6_seq_errors", errs, 0);
        vcnt = 0;
        foreach (vld_log[i]) if (vld_log[i]) vcnt++;
        check_val("t6_valid_cycles", vcnt, 520);
        check_val("t6_done_cyc", done_cyc, 520);
        check_val("t6_beat_count", beat_count8, 520);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
